ps2_keyboard_rx: RTL and testbench

Host-side PS/2 receiver. It takes the keyboard's ps2_clk/ps2_data lines and recovers the serial frames the keyboard transmits. It then decodes those scan-code bytes into make/break key events and held arrow-key levels for the Tetris game logic. It sits beside the VGA display path on the 100 MHz system clock, and its arrow outputs replace the raw up/down/left/right board inputs.

---
 rtl/ps2_keyboard_rx.sv | 254 +++++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// Host-side PS/2 keyboard receiver.
//
// The block conditions the keyboard's ps2_clk/ps2_data lines and
// deserialises 11-bit frames: start, 8 data bits LSB first, odd parity
// and stop. The received scan codes are then decoded into key events.
// The E0 prefix marks an extended key and the F0 prefix marks a break.
//
// Optional build macro: PS2_ARROW_KEYS_EN
//   defined   - up/down/left/right follow the extended arrow keys.
//   undefined - up/down/left/right are tied low.
//
// Ports:
//   clk          in   100 MHz system clock
//   reset        in   asynchronous reset, active low
//   ps2_clk      in   PS/2 clock line (input only)
//   ps2_data     in   PS/2 data line (input only)
//   rx_data      out  last correctly received byte
//   rx_valid     out  1-cycle pulse when rx_data updates
//   frame_err    out  1-cycle pulse on a parity, stop or timeout error
//   key_code     out  scan code of the last key event
//   key_release  out  1 = break event
//   key_extended out  1 = E0-prefixed event
//   key_valid    out  1-cycle pulse when the key_* outputs update
//   up/down/left/right out  held level: arrow key currently pressed
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       key_extended,
    output logic       key_valid,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ---------------- input conditioning ----------------
    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt, data_filt, clk_filt_d;
    logic [FW-1:0] clk_cnt, data_cnt;
    logic          fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // A filtered line only follows its synchronized input once the input
    // has disagreed with it for FILTER_LEN samples in a row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_filt <= 1'b1;
            clk_cnt  <= '0;
        end else if (clk_sync[1] == clk_filt) begin
            clk_cnt <= '0;
        end else if (clk_cnt == F_LAST) begin
            clk_filt <= clk_sync[1];
            clk_cnt  <= '0;
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_filt <= 1'b1;
            data_cnt  <= '0;
        end else if (data_sync[1] == data_filt) begin
            data_cnt <= '0;
        end else if (data_cnt == F_LAST) begin
            data_filt <= data_sync[1];
            data_cnt  <= '0;
        end else begin
            data_cnt <= data_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) clk_filt_d <= 1'b1;
        else        clk_filt_d <= clk_filt;
    end

    assign fall = clk_filt_d & ~clk_filt;

    // ---------------- frame deserialiser ----------------
    state_t        state, state_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shift, shift_nx;
    logic          par, par_nx;
    logic [WW-1:0] wd, wd_nx;
    logic [7:0]    rx_data_nx;
    logic          rx_valid_nx, frame_err_nx;
    logic          timeout;

    // The watchdog only runs inside a frame. A falling edge in the same
    // cycle wins, so a timeout can never coincide with a stop-bit result.
    assign timeout = (state != IDLE) && !fall && (wd == WD_MAX);

    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        shift_nx     = shift;
        par_nx       = par;
        rx_data_nx   = rx_data;
        rx_valid_nx  = 1'b0;
        frame_err_nx = 1'b0;
        wd_nx        = (state == IDLE || fall) ? '0 : wd + 1'b1;

        case (state)
            IDLE: begin
                if (fall && !data_filt) begin
                    state_nx   = DATA;
                    bit_cnt_nx = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_nx   = {data_filt, shift[7:1]};
                    bit_cnt_nx = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_nx = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_nx   = data_filt;
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    if (data_filt && ((^shift) ^ par)) begin
                        rx_data_nx  = shift;
                        rx_valid_nx = 1'b1;
                    end else begin
                        frame_err_nx = 1'b1;
                    end
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (timeout) begin
            state_nx     = IDLE;
            frame_err_nx = 1'b1;
            wd_nx        = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            wd        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            wd        <= wd_nx;
            rx_data   <= rx_data_nx;
            rx_valid  <= rx_valid_nx;
            frame_err <= frame_err_nx;
        end
    end

    // The partial byte is never observed outside a completed frame.
    always_ff @(posedge clk) begin
        shift <= shift_nx;
        par   <= par_nx;
    end

    // ---------------- key event layer ----------------
    logic ext_flag, brk_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            key_code     <= '0;
            key_release  <= 1'b0;
            key_extended <= 1'b0;
            key_valid    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (rx_valid) begin
                case (rx_data)
                    8'hE0: ext_flag <= 1'b1;
                    8'hF0: brk_flag <= 1'b1;
                    default: begin
                        key_code     <= rx_data;
                        key_release  <= brk_flag;
                        key_extended <= ext_flag;
                        key_valid    <= 1'b1;
                        ext_flag     <= 1'b0;
                        brk_flag     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------- arrow key levels ----------------
`ifdef PS2_ARROW_KEYS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up    <= 1'b0;
            down  <= 1'b0;
            left  <= 1'b0;
            right <= 1'b0;
        end else if (key_valid && key_extended) begin
            case (key_code)
                8'h75: up    <= ~key_release;
                8'h72: down  <= ~key_release;
                8'h6B: left  <= ~key_release;
                8'h74: right <= ~key_release;
                default: ;
            endcase
        end
    end
`else
    assign up    = 1'b0;
    assign down  = 1'b0;
    assign left  = 1'b0;
    assign right = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;

    localparam int FLEN = 8;
    localparam int TMO  = 2000;
    localparam int HALF = 20;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_extended;
    logic       key_valid;
    logic       up, down, left, right;

    ps2_keyboard_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .key_code(key_code), .key_release(key_release),
        .key_extended(key_extended), .key_valid(key_valid),
        .up(up), .down(down), .left(left), .right(right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } rx_exp_t;

    typedef struct packed {
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } key_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic       exp_err;
        logic       has_key;
        logic [7:0] k_code;
        logic       k_rel;
        logic       k_ext;
        logic [3:0] arrows;   // {up,down,left,right} when arrows are built in
    } vec_t;

    rx_exp_t    rx_q[$];
    key_exp_t   key_q[$];
    vec_t       vt[$];
    int         checks = 0;
    int         passed = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive the first n bits of a frame, bit 0 first. Data changes while
    // ps2_clk is high; glitch_idx selects a bit whose high phase carries a
    // short ps2_clk low pulse.
    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_idx);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (i == glitch_idx) begin
                wait_clk(5);
                ps2_clk = 1'b0;
                wait_clk(5);
                ps2_clk = 1'b1;
                wait_clk(HALF - 10);
            end else begin
                wait_clk(HALF);
            end
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_par,
                                               input logic bad_stop);
        logic p;
        p = ~(^d) ^ bad_par;
        return {~bad_stop, p, d, 1'b0};
    endfunction

    function automatic logic [3:0] exp_arrows(input logic [3:0] a);
`ifdef PS2_ARROW_KEYS_EN
        return a;
`else
        return 4'b0000 & a;
`endif
    endfunction

    task automatic monitor();
        rx_exp_t  e;
        key_exp_t k;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (rx_valid || frame_err) begin
                    if (rx_q.size() == 0) begin
                        chk("unexpected_rx_event", {30'd0, rx_valid, frame_err}, 32'd0);
                    end else begin
                        e = rx_q.pop_front();
                        chk("rx_kind", {30'd0, rx_valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
                        if (e.is_err) begin
                            chk("rx_data_hold", {24'd0, rx_data}, {24'd0, last_good});
                        end else begin
                            chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                            last_good = e.data;
                        end
                    end
                end
                if (key_valid) begin
                    if (key_q.size() == 0) begin
                        chk("unexpected_key_event", {31'd0, key_valid}, 32'd0);
                    end else begin
                        k = key_q.pop_front();
                        chk("key_event", {22'd0, key_code, key_release, key_extended},
                            {22'd0, k.code, k.rel, k.ext});
                    end
                end
            end
        end
    endtask

    task automatic add(input logic [7:0] d, input logic bp, input logic bs, input logic er,
                       input logic hk, input logic [7:0] kc, input logic kr, input logic ke,
                       input logic [3:0] ar);
        vec_t v;
        v.data = d; v.bad_par = bp; v.bad_stop = bs; v.exp_err = er;
        v.has_key = hk; v.k_code = kc; v.k_rel = kr; v.k_ext = ke; v.arrows = ar;
        vt.push_back(v);
    endtask

    initial begin
        //   data   bpar  bstop err   key   code   rel   ext   {u,d,l,r}
        add(8'h1C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        add(8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        add(8'h29, 1'b0, 1'b0, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0, 4'b0000);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        add(8'h6B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h6B, 1'b0, 1'b1, 4'b0010);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0010);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0010);
        add(8'h6B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b1, 4'b0000);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        add(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0, 4'b0000);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        add(8'h74, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        add(8'h29, 1'b0, 1'b0, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0, 4'b0000);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        add(8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 8'h75, 1'b0, 1'b1, 4'b1000);
        add(8'h74, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1000);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1000);
        add(8'h72, 1'b0, 1'b0, 1'b0, 1'b1, 8'h72, 1'b0, 1'b1, 4'b1100);
        add(8'h29, 1'b0, 1'b0, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0, 4'b1100);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1100);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b1100);
        add(8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 4'b0100);
        add(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0100);
        add(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0100);
        add(8'h72, 1'b0, 1'b0, 1'b0, 1'b1, 8'h72, 1'b1, 1'b1, 4'b0000);

        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        fork
            monitor();
        join_none

        // Reset state.
        wait_clk(3);
        @(negedge clk);
        chk("reset_outputs", {7'd0, rx_data, rx_valid, frame_err, key_code, key_release,
                              key_extended, key_valid, up, down, left, right}, 32'd0);
        reset = 1'b1;
        wait_clk(10);

        // Reset in the middle of a frame: start + 3 bits, then reset.
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 4, -1);
        wait_clk(3);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("outputs_in_reset", {7'd0, rx_data, rx_valid, frame_err, key_code, key_release,
                                     key_extended, key_valid, up, down, left, right}, 32'd0);
            wait_clk(2);
        end
        reset = 1'b1;
        wait_clk(20);
        rx_q.push_back('{1'b0, 8'h1C});
        key_q.push_back('{8'h1C, 1'b0, 1'b0});
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11, -1);
        wait_clk(30);

        // Table of whole frames.
        foreach (vt[i]) begin
            rx_q.push_back('{vt[i].exp_err, vt[i].data});
            if (vt[i].has_key) key_q.push_back('{vt[i].k_code, vt[i].k_rel, vt[i].k_ext});
            send_bits(make_frame(vt[i].data, vt[i].bad_par, vt[i].bad_stop), 11, -1);
            wait_clk(30);
            @(negedge clk);
            chk($sformatf("arrows_%0d", i), {28'd0, up, down, left, right},
                {28'd0, exp_arrows(vt[i].arrows)});
        end
        chk("table_rx_drained", rx_q.size(), 32'd0);

        // Watchdog: start + 3 bits, then silence past the timeout.
        rx_q.push_back('{1'b1, 8'h00});
        send_bits(make_frame(8'h5A, 1'b0, 1'b0), 4, -1);
        wait_clk(TMO + 200);
        chk("timeout_frame_err", rx_q.size(), 32'd0);
        rx_q.push_back('{1'b0, 8'h1C});
        key_q.push_back('{8'h1C, 1'b0, 1'b0});
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11, -1);
        wait_clk(30);

        // Short ps2_clk glitch in a frame must not add a bit.
        rx_q.push_back('{1'b0, 8'h75});
        key_q.push_back('{8'h75, 1'b0, 1'b0});
        send_bits(make_frame(8'h75, 1'b0, 1'b0), 11, 3);
        wait_clk(30);
        @(negedge clk);
        chk("arrows_after_glitch", {28'd0, up, down, left, right}, 32'd0);

        chk("rx_queue_empty", rx_q.size(), 32'd0);
        chk("key_queue_empty", key_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
